// File: rtl/gic_pkg.sv
// Shared register map and priority type for the gic_reg_block interrupt controller.
package gic_pkg;

  localparam int PRIO_W = 4;

  localparam logic [7:0] CTRL_A    = 8'h00;
  localparam logic [7:0] ENABLE_A  = 8'h04;
  localparam logic [7:0] PENDING_A = 8'h08;
  localparam logic [7:0] RAW_A     = 8'h0C;
  localparam logic [7:0] PRIO0_A   = 8'h10;
  localparam logic [7:0] PRIO1_A   = 8'h14;
  localparam logic [7:0] PRIO2_A   = 8'h18;
  localparam logic [7:0] PRIO3_A   = 8'h1C;
  localparam logic [7:0] THRESH_A  = 8'h20;
  localparam logic [7:0] CLAIM_A   = 8'h24;
  localparam logic [7:0] EOI_A     = 8'h28;

  typedef logic [PRIO_W-1:0] prio_t;

endpackage

// File: rtl/gic_arbiter.sv
// Combinational winner select: highest priority among eligible sources, lowest index on ties.
module gic_arbiter #(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = 4
) (
  input  logic [NUM_IRQ-1:0]        eligible,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio,
  output logic                      valid,
  output logic [4:0]                id
);
  import gic_pkg::*;

  prio_t best;

  // Strict '>' keeps the earlier (lower) index when priorities tie.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    best  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (eligible[i] && (!valid || prio[i*PRIO_W +: PRIO_W] > best)) begin
        valid = 1'b1;
        id    = 5'(i);
        best  = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule

// File: rtl/gic_reg_block.sv
// Register-programmed interrupt controller: edge-latched pending bits, enable/priority
// masking and a registered winner ID, all behind an 8-bit/32-bit register bus.
module gic_reg_block #(
  parameter int NUM_IRQ = 32,
  parameter int PRIO_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         addr,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out,
  output logic [4:0]         irq_id
);
  import gic_pkg::*;

  logic                      ctrl_en;
  logic [NUM_IRQ-1:0]        enable_q;
  logic [NUM_IRQ-1:0]        pending_q;
  logic [NUM_IRQ-1:0]        irq_q;
  logic [NUM_IRQ*PRIO_W-1:0] prio_q;
  logic [PRIO_W-1:0]         thresh_q;

  logic [7:0]         a_w;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [127:0]       prio_full;
  logic [31:0]        rd_word;
  logic               win_valid;
  logic [4:0]         win_id;
  logic               unused_bits;

  assign a_w         = {addr[7:2], 2'b00};
  assign rise        = irq_in & ~irq_q;
  assign unused_bits = ^{addr[1:0], wdata};

  always_comb begin
    clr = '0;
    if (wr_en && a_w == PENDING_A) clr = wdata[NUM_IRQ-1:0];
    if (wr_en && a_w == EOI_A) begin
      for (int i = 0; i < NUM_IRQ; i++)
        if (wdata[4:0] == 5'(i)) clr[i] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++)
      eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i*PRIO_W +: PRIO_W] > thresh_q);
  end

  gic_arbiter #(.NUM_IRQ(NUM_IRQ), .PRIO_W(PRIO_W)) u_arb (
    .eligible (eligible),
    .prio     (prio_q),
    .valid    (win_valid),
    .id       (win_id)
  );

  always_comb begin
    prio_full = '0;
    prio_full[NUM_IRQ*PRIO_W-1:0] = prio_q;
  end

  always_comb begin
    rd_word = '0;
    case (a_w)
      CTRL_A:    rd_word = {31'b0, ctrl_en};
      ENABLE_A:  rd_word = 32'(enable_q);
      PENDING_A: rd_word = 32'(pending_q);
      RAW_A:     rd_word = 32'(irq_in);
      PRIO0_A:   rd_word = prio_full[31:0];
      PRIO1_A:   rd_word = prio_full[63:32];
      PRIO2_A:   rd_word = prio_full[95:64];
      PRIO3_A:   rd_word = prio_full[127:96];
      THRESH_A:  rd_word = 32'(thresh_q);
      CLAIM_A:   rd_word = {irq_out, 26'b0, irq_id};
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en   <= 1'b0;
      enable_q  <= '0;
      pending_q <= '0;
      irq_q     <= '0;
      prio_q    <= '0;
      thresh_q  <= '0;
      rdata     <= '0;
      irq_out   <= 1'b0;
      irq_id    <= '0;
    end else begin
      irq_q     <= irq_in;
      // A new edge in the same cycle as a clear must not be lost.
      pending_q <= (pending_q & ~clr) | rise;
      irq_out   <= ctrl_en & win_valid;
      irq_id    <= win_valid ? win_id : 5'd0;
      if (rd_en) rdata <= rd_word;
      if (wr_en) begin
        if (a_w == CTRL_A)   ctrl_en  <= wdata[0];
        if (a_w == ENABLE_A) enable_q <= wdata[NUM_IRQ-1:0];
        if (a_w == THRESH_A) thresh_q <= wdata[PRIO_W-1:0];
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (a_w == PRIO0_A + 8'(4*(i/8)))
            prio_q[i*PRIO_W +: PRIO_W] <= wdata[(i%8)*PRIO_W +: PRIO_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_gic_reg_block.sv
// Directed bench for gic_reg_block: bus access, edge latching, arbitration and masking.
module tb_gic_reg_block;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] irq_in;
  logic        irq_out;
  logic [4:0]  irq_id;

  int n_checks = 0;
  int n_errors = 0;

  gic_reg_block #(.NUM_IRQ(32), .PRIO_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_in  (irq_in),
    .irq_out (irq_out),
    .irq_id  (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
    d = rdata;
  endtask

  task automatic pulse_irq(input logic [31:0] m);
    @(negedge clk);
    irq_in = m;
    @(negedge clk);
    irq_in = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  logic [31:0] d;

  initial begin
    rst_n = 1'b0; addr = '0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0; irq_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    for (int a = 0; a <= 'h28; a += 4) begin
      bus_rd(8'(a), d);
      chk($sformatf("reset_rd_%02h", a), d, 32'h0);
    end
    chk("reset_irq_out", {31'b0, irq_out}, 32'h0);
    chk("reset_irq_id", {27'b0, irq_id}, 32'h0);

    bus_wr(8'h04, 32'hA5A5_5A5A);
    bus_rd(8'h04, d);  chk("enable_rb", d, 32'hA5A5_5A5A);
    bus_wr(8'h40, 32'hFFFF_FFFF);
    bus_rd(8'h40, d);  chk("unmapped_rd", d, 32'h0);
    bus_wr(8'h0C, 32'hFFFF_FFFF);
    bus_rd(8'h0C, d);  chk("raw_ro", d, 32'h0);
    bus_rd(8'h2B, d);  chk("enable_lowbits_ign", d, 32'h0);

    // Simultaneous read and write returns the old contents.
    @(negedge clk);
    addr = 8'h04; wdata = 32'h0000_0008; wr_en = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdwr_old", rdata, 32'hA5A5_5A5A);
    bus_rd(8'h04, d);  chk("rdwr_new", d, 32'h0000_0008);

    // Single source 3, prio 5 over threshold 2.
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h10, 32'h0000_5000);
    bus_wr(8'h20, 32'h2);
    @(negedge clk); irq_in = 32'h8;
    tick();
    chk("single_lat1_out", {31'b0, irq_out}, 32'h0);
    @(negedge clk); irq_in = '0;
    tick();
    chk("single_out", {31'b0, irq_out}, 32'h1);
    chk("single_id", {27'b0, irq_id}, 32'd3);
    bus_rd(8'h24, d);  chk("claim", d, 32'h8000_0003);
    bus_wr(8'h28, 32'd3);
    chk("eoi_lat_out", {31'b0, irq_out}, 32'h1);
    tick();
    chk("eoi_out_drop", {31'b0, irq_out}, 32'h0);
    bus_rd(8'h28, d);  chk("eoi_rd0", d, 32'h0);

    // Arbitration: 2 and 7 at prio 6, 9 at prio 4.
    bus_wr(8'h04, 32'h0000_0284);
    bus_wr(8'h10, 32'h6000_0600);
    bus_wr(8'h14, 32'h0000_0040);
    bus_rd(8'h14, d);  chk("prio1_rb", d, 32'h0000_0040);
    pulse_irq(32'h0000_0284);
    tick();
    chk("arb_first", {27'b0, irq_id}, 32'd2);
    bus_wr(8'h28, 32'd2); tick();
    chk("arb_second", {27'b0, irq_id}, 32'd7);
    bus_wr(8'h28, 32'd7); tick();
    chk("arb_third", {27'b0, irq_id}, 32'd9);
    chk("arb_third_out", {31'b0, irq_out}, 32'h1);
    bus_wr(8'h28, 32'd9); tick();
    chk("arb_empty_out", {31'b0, irq_out}, 32'h0);
    chk("arb_empty_id", {27'b0, irq_id}, 32'd0);

    // Masking by threshold and global enable.
    bus_wr(8'h04, 32'h0000_0020);
    bus_wr(8'h10, 32'h0010_0000);
    bus_wr(8'h20, 32'h1);
    pulse_irq(32'h0000_0020);
    tick();
    chk("mask_thresh_out", {31'b0, irq_out}, 32'h0);
    chk("mask_thresh_id", {27'b0, irq_id}, 32'd0);
    bus_wr(8'h20, 32'h0); tick();
    chk("thresh0_out", {31'b0, irq_out}, 32'h1);
    chk("thresh0_id", {27'b0, irq_id}, 32'd5);
    bus_wr(8'h00, 32'h0); tick();
    chk("ctrl_off_out", {31'b0, irq_out}, 32'h0);
    chk("ctrl_off_id", {27'b0, irq_id}, 32'd5);
    bus_rd(8'h08, d);  chk("ctrl_off_pend", d, 32'h0000_0020);
    bus_wr(8'h08, 32'h0000_0001);
    bus_rd(8'h08, d);  chk("rw1c_other", d, 32'h0000_0020);
    bus_wr(8'h08, 32'h0000_0020);
    bus_rd(8'h08, d);  chk("rw1c_clear", d, 32'h0);

    // Set beats RW1C clear in the same cycle.
    @(negedge clk);
    irq_in = 32'h10; addr = 8'h08; wdata = 32'h10; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    bus_rd(8'h08, d);  chk("coll_rw1c", d, 32'h0000_0010);
    bus_wr(8'h08, 32'h10);
    bus_rd(8'h08, d);  chk("level_no_reset", d, 32'h0);
    bus_rd(8'h0C, d);  chk("raw_level", d, 32'h0000_0010);

    // Set beats EOI clear in the same cycle.
    @(negedge clk); irq_in = '0;
    @(negedge clk);
    irq_in = 32'h10; addr = 8'h28; wdata = 32'd4; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    bus_rd(8'h08, d);  chk("coll_eoi", d, 32'h0000_0010);

    // Reset mid-operation drops pending state.
    @(negedge clk); irq_in = '0;
    bus_wr(8'h00, 32'h1);
    bus_wr(8'h04, 32'h10);
    bus_wr(8'h10, 32'h0009_0000);
    tick();
    chk("pre_rst_out", {31'b0, irq_out}, 32'h1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("async_rst_out", {31'b0, irq_out}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    bus_rd(8'h08, d);  chk("post_rst_pend", d, 32'h0);
    bus_rd(8'h00, d);  chk("post_rst_ctrl", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gic_reg_block.md
# gic_reg_block

Register-programmed interrupt controller behind the 8-bit-address / 32-bit-data register bus. It sits between peripheral interrupt lines and a single CPU interrupt input. It latches rising edges on up to 32 sources into pending bits, masks them by per-source enable and priority, and arbitrates to one winning source ID. Software clears a serviced source by writing its ID to an end-of-interrupt register.

## Interface
- `NUM_IRQ`, default 32: number of interrupt sources, legal range 1..32. Unused register bits read 0.
- `PRIO_W`, default 4: priority field width, fixed at 4.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  bus and core clock
- `rst_n`  in  1  asynchronous active-low reset
- `addr`  in  8  byte address; bits [1:0] ignored
- `wr_en`  in  1  write strobe, sampled at posedge
- `rd_en`  in  1  read strobe, sampled at posedge
- `wdata`  in  32  write data
- `rdata`  out  32  registered read data
- `irq_in`  in  NUM_IRQ  interrupt source lines, synchronous to `clk`
- `irq_out`  out  1  interrupt request to CPU
- `irq_id`  out  5  ID of the current winning source

## Operation
Register map (all registers 32-bit):
- 0x00 CTRL, RW: bit0 = global enable.
- 0x04 ENABLE, RW: per-source enable mask.
- 0x08 PENDING, RW1C: read returns pending bits; writing 1 clears the bit.
- 0x0C RAW, RO: current `irq_in` level.
- 0x10/0x14/0x18/0x1C PRIO0..3, RW: 4-bit priority per source, 8 sources per word. Source n occupies PRIO[n/8], bits [4*(n%8)+3 : 4*(n%8)].
- 0x20 THRESH, RW: bits[3:0] = priority threshold.
- 0x24 CLAIM, RO: bit31 = `irq_out`, bits[4:0] = `irq_id`.
- 0x28 EOI, WO: writing ID k clears pending[k]; reads return 0.

Pending and arbitration:
- pending[n] is set on a rising edge of `irq_in[n]`, detected against a 1-cycle registered copy of `irq_in`.
- Set wins over a simultaneous clear, whether the clear comes from RW1C or EOI.
- A source is eligible when pending, enabled, and priority > THRESH. Priority 0 therefore never interrupts.
- Winner: highest priority; on a tie, the lowest index wins.
- `irq_out` = CTRL.en && any source eligible.
- `irq_id` = winner index, or 0 when no source is eligible.

Bus:
- Unmapped addresses read 0; writes to them are ignored.
- `wr_en` and `rd_en` in the same cycle: both are performed. Read data reflects pre-write register contents.
- Writes to RO registers are ignored.

## Timing
- Reset: all registers 0, `rdata` = 0, `irq_out` = 0, `irq_id` = 0, and the edge-detect register = 0. A source that is already high when reset is released therefore creates a pending bit one cycle after the first sampled high.
- Write: takes effect at the posedge where `wr_en` = 1; it is visible to a read one cycle later.
- Read: `rdata` is loaded at the posedge where `rd_en` = 1 and held until the next read.
- `irq_in` rising, to pending set: 1 cycle. Pending change, to `irq_out`/`irq_id` update: 1 cycle (registered outputs). `irq_in` edge to `irq_out` is 2 cycles total.
- Reset asserted mid-operation: all state clears immediately; pending events are lost.

## Structure
- Shared package `gic_pkg`: register address localparams (`CTRL_A` .. `EOI_A`), `PRIO_W`, and a `prio_t` typedef.
- Sub-module `gic_arbiter`: combinational, takes the eligible mask plus priorities and returns `{valid, id}`. The top level holds the register file, edge detect and output registers.

## Test plan
- Reset: after `rst_n` deasserts, read all of 0x00–0x28; every read returns 0 and `irq_out` = 0.
- Write/read: write ENABLE = 0xA5A5_5A5A, then read it back and get 0xA5A5_5A5A. Read 0x40 and get 0.
- Single IRQ: set CTRL = 1, ENABLE[3] = 1, priority of source 3 = 5, THRESH = 2, then pulse `irq_in[3]`. Required: `irq_out` = 1 and `irq_id` = 3 two cycles later, and CLAIM reads 0x8000_0003. Write EOI = 3; `irq_out` drops 1 cycle later.
- Arbitration: sources 2 and 7 both pending with priority 6; source 9 pending with priority 4. Required: `irq_id` = 2. After EOI 2, `irq_id` = 7. After EOI 7, `irq_id` = 9.
- Masking: with source 5 pending, priority of source 5 = 1 and THRESH = 1, so `irq_out` = 0. Change THRESH to 0 and `irq_out` = 1. Clear CTRL.en and `irq_out` = 0 while PENDING still reads bit5 = 1.
- Set/clear collision: write PENDING = 0x10 in the same cycle that a rising edge on `irq_in[4]` is detected. Required: PENDING[4] remains 1.
